display_source_ctrl: RTL



---
 rtl/display_pkg.sv | 22 ++
 rtl/display_source_ctrl_step_sync.sv | 28 ++
 rtl/display_source_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the hex-display source selector.
package display_pkg;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        AUTO   = 2'd1,
        FROZEN = 2'd2
    } disp_state_t;

    localparam int NSRC_DEFAULT = 4;
    localparam int SRC_BITS     = 32;

    // Index width for nsrc sources; a single source still gets one bit.
    function automatic int src_idx_w(input int nsrc);
        return (nsrc < 2) ? 1 : $clog2(nsrc);
    endfunction

    function automatic int src_lsb(input int idx);
        return SRC_BITS * idx;
    endfunction

endpackage

// File: rtl/display_source_ctrl_step_sync.sv
// Two-flop synchronizer plus rising-edge register for a raw board button.
// The pulse is one clock wide and appears two edges after the first sampling edge.
module step_sync (
    input  logic clock,
    input  logic resetn,
    input  logic din,
    output logic rise
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
            rise   <= 1'b0;
        end else begin
            meta   <= din;
            sync   <= meta;
            sync_d <= sync;
            rise   <= sync & ~sync_d;
        end
    end

endmodule

// File: rtl/display_source_ctrl.sv
// Shadows NSRC debug words and picks the one shown on the 8-digit hex display.
//  state  | meaning
//  MANUAL | each synchronized step edge advances the selection
//  AUTO   | selection advances every DWELL_CYCLES; a step edge also advances
//  FROZEN | shadows, selection, val and changed held; step edges discarded
module display_source_ctrl
    import display_pkg::*;
#(
    parameter int NSRC         = NSRC_DEFAULT,
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [NSRC*SRC_BITS-1:0]   src_data,
    input  logic [NSRC-1:0]            src_valid,
    input  logic                       step,
    input  logic                       auto_en,
    input  logic                       freeze,
    output logic [SRC_BITS-1:0]        val,
    output logic [src_idx_w(NSRC)-1:0] cur_src,
    output logic                       changed
);

    localparam int            IW       = src_idx_w(NSRC);
    localparam int            CW       = $clog2(DWELL_CYCLES);
    localparam logic [IW-1:0] LAST_SRC = IW'(NSRC - 1);
    localparam logic [CW-1:0] TERM_CNT = CW'(DWELL_CYCLES - 1);

    disp_state_t         state;
    disp_state_t         state_next;
    logic [CW-1:0]       dwell;
    logic [CW-1:0]       dwell_next;
    logic [IW-1:0]       cur_next;
    logic                changed_next;
    logic                advance;
    logic                step_rise;
    logic [SRC_BITS-1:0] src_word [NSRC];
    logic [SRC_BITS-1:0] shadow   [NSRC];

    step_sync u_step_sync (
        .clock  (clock),
        .resetn (resetn),
        .din    (step),
        .rise   (step_rise)
    );

    for (genvar i = 0; i < NSRC; i++) begin : g_word
        assign src_word[i] = src_data[src_lsb(i) +: SRC_BITS];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NSRC; i++) shadow[i] <= '0;
        end else if (!freeze) begin
            for (int i = 0; i < NSRC; i++) begin
                if (src_valid[i]) shadow[i] <= src_word[i];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= MANUAL;
            dwell   <= '0;
            cur_src <= '0;
            changed <= 1'b0;
            val     <= '0;
        end else begin
            state   <= state_next;
            dwell   <= dwell_next;
            cur_src <= cur_next;
            changed <= changed_next;
            if (state_next != FROZEN) val <= shadow[cur_src];
        end
    end

    // The mode is taken from this cycle's levels; a mode differing from the
    // registered state is a transition, which leaves the dwell counter at zero.
    always_comb begin
        state_next = MANUAL;
        dwell_next = '0;
        advance    = 1'b0;
        if (freeze) begin
            state_next = FROZEN;
        end else if (auto_en) begin
            state_next = AUTO;
        end

        case (state_next)
            AUTO: begin
                advance = step_rise || (state == AUTO && dwell == TERM_CNT);
                if (state == AUTO && !advance) dwell_next = dwell + CW'(1);
            end
            MANUAL:  advance = step_rise;
            default: advance = 1'b0;
        endcase

        cur_next = cur_src;
        if (advance) cur_next = (cur_src == LAST_SRC) ? '0 : cur_src + IW'(1);

        changed_next = changed;
        if (advance) begin
            changed_next = 1'b0;
        end else if (!freeze && src_valid[cur_src]) begin
            changed_next = 1'b1;
        end
    end

endmodule
